// File: rtl/binary_to_bcd_encoder.sv
// binary_to_bcd_encoder
//   Free-running signed binary to sign-magnitude BCD converter. Each 20-cycle
//   period samples an 18-bit two's-complement input once. The magnitude is
//   converted with shift-and-add-3, one bit per clock. The result is presented
//   as a sign bit plus five BCD digits. Magnitudes above 99999 saturate.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   LOAD  | sample sign and magnitude, clear scratch and bit counter
//   SHIFT | 18 cycles of add-3 adjust followed by a 1-bit left shift
//   DONE  | write result (or saturated 99999) to BCDoutput, pulse v
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   binaryInput  18-bit signed value, sampled in LOAD only
//   BCDoutput    {sign, 5 BCD digits}, registered, held between updates
//   v            one-cycle pulse following each BCDoutput update

module binary_to_bcd_encoder (
   input  logic        clk,
   input  logic        rst,
   input  logic [17:0] binaryInput,
   output logic [20:0] BCDoutput,
   output logic        v
);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic        sign_q;
   logic [17:0] mag_q;
   logic [23:0] scratch_q;
   logic [4:0]  cnt_q;
   logic [17:0] abs_in;
   logic [23:0] scratch_adj;

   // -131072 negates to itself as an 18-bit pattern, 18'h20000.
   // Read as unsigned, that pattern is the correct magnitude.
   assign abs_in = binaryInput[17] ? (~binaryInput + 18'd1) : binaryInput;

   always_comb begin
      scratch_adj = scratch_q;
      for (int i = 0; i < 6; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) begin
            scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD:    state_d = SHIFT;
         SHIFT:   if (cnt_q == 5'd17) state_d = DONE;
         DONE:    state_d = LOAD;
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= LOAD;
         sign_q    <= 1'b0;
         mag_q     <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         BCDoutput <= '0;
         v         <= 1'b0;
      end else begin
         state_q <= state_d;
         v       <= 1'b0;
         case (state_q)
            LOAD: begin
               sign_q    <= binaryInput[17];
               mag_q     <= abs_in;
               scratch_q <= '0;
               cnt_q     <= '0;
            end
            SHIFT: begin
               {scratch_q, mag_q} <= {scratch_adj[22:0], mag_q, 1'b0};
               cnt_q              <= cnt_q + 5'd1;
            end
            DONE: begin
               if (scratch_q[23:20] == 4'd0) begin
                  BCDoutput <= {sign_q, scratch_q[19:0]};
               end else begin
                  BCDoutput <= {sign_q, 20'h99999};
               end
               v <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_binary_to_bcd_encoder.sv
// Testbench for binary_to_bcd_encoder.
// Expected results are queued at each LOAD edge and popped when v pulses.
// The LOAD edges are found by counting edges since reset release.

module tb_binary_to_bcd_encoder;

   logic        clk;
   logic        rst;
   logic [17:0] binaryInput;
   logic [20:0] BCDoutput;
   logic        v;

   int          n_checks = 0;
   int          n_errors = 0;
   int          edge_cnt = 0;
   logic [20:0] exp_q[$];

   binary_to_bcd_encoder dut (
      .clk         (clk),
      .rst         (rst),
      .binaryInput (binaryInput),
      .BCDoutput   (BCDoutput),
      .v           (v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [20:0] model(input logic [17:0] x);
      int m;
      logic s;
      s = x[17];
      m = s ? -$signed({{14{x[17]}}, x}) : int'(x);
      if (m > 99999) m = 99999;
      return {s, 4'(m / 10000), 4'((m / 1000) % 10), 4'((m / 100) % 10),
              4'((m / 10) % 10), 4'(m % 10)};
   endfunction

   // Track the converter's period.
   // The first edge after reset release is a LOAD edge.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         edge_cnt = 0;
         exp_q.delete();
      end else begin
         edge_cnt++;
         if (edge_cnt % 20 == 1) exp_q.push_back(model(binaryInput));
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         check("v_timing", 32'(v), 32'((edge_cnt > 0) && (edge_cnt % 20 == 0)));
         if (v) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
               check("bcd", 32'(BCDoutput), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   int vals[17] = '{1, 12, 123, 1234, 12345, 123456, 131071,
                    -1, -12, -123, -1234, -12345, -131072,
                    99999, 100000, 9, 10};

   initial begin
      rst         = 1'b0;
      binaryInput = '0;
      repeat (3) @(negedge clk);
      check("rst_bcd", 32'(BCDoutput), 32'd0);
      check("rst_v", 32'(v), 32'd0);
      rst = 1'b1;
      repeat (45) @(negedge clk);

      foreach (vals[i]) begin
         binaryInput = 18'(vals[i]);
         repeat (30) @(negedge clk);
      end

      // Let the last value (10) settle on BCDoutput.
      // Then abort a conversion part-way through its SHIFT phase.
      binaryInput = 18'(-4321);
      repeat (45) @(negedge clk);
      for (int k = 0; k < 25; k++) begin
         if (edge_cnt % 20 == 8) break;
         @(negedge clk);
      end
      check("pre_abort_bcd", 32'(BCDoutput), 32'(model(18'(-4321))));
      #2 rst = 1'b0;
      #1;
      check("abort_bcd", 32'(BCDoutput), 32'd0);
      check("abort_v", 32'(v), 32'd0);
      @(negedge clk);
      binaryInput = 18'd777;
      rst = 1'b1;
      repeat (45) @(negedge clk);

      check("pending", 32'(exp_q.size() <= 1), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/binary_to_bcd_encoder.md
Name: binary_to_bcd_encoder

Overview:
- Sequential signed-binary to sign-magnitude BCD converter.
- Samples an 18-bit two's-complement value and converts its magnitude with the shift-and-add-3 (double-dabble) algorithm, one bit per clock.
- Presents a sign bit plus five BCD digits, with a one-cycle valid pulse per conversion.
- Free-running: no start input. Used ahead of 7-segment/display logic.

Parameters:
- none (input width fixed at 18 bits, output at 1 sign bit + 5 BCD digits)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- binaryInput  input  18  signed two's-complement value to convert; sampled only in LOAD state
- BCDoutput  output  21  [20] = sign (1 = negative); [19:16] ten-thousands, [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units; registered
- v  output  1  registered valid pulse: high for exactly one cycle when BCDoutput has just been updated

Behaviour:
- One clock; reset is asynchronous and active-low (rst low clears immediately, independent of clk).
- Reset values:
  - BCDoutput = 21'h000000, v = 0, state = LOAD.
  - Internal shift register, BCD scratch and bit counter are cleared.
  - Reset mid-conversion aborts the conversion; no partial result is ever written to BCDoutput.
- FSM has three states, cycling continuously LOAD -> SHIFT -> DONE -> LOAD.
- LOAD (1 cycle):
  - Capture sign = binaryInput[17].
  - Capture magnitude = |binaryInput| as 18-bit unsigned; -131072 yields 131072, which fits in 18 bits.
  - Clear 24-bit scratch (6 digits) and bit counter; go to SHIFT.
- SHIFT (18 cycles):
  - Each edge, every scratch digit >= 5 gets +3.
  - Then {scratch, magnitude} shifts left by 1; the magnitude MSB enters the scratch LSB.
  - Counter increments; after the 18th shift go to DONE.
- DONE (1 cycle), on the exit edge:
  - If hundred-thousands digit == 0: BCDoutput <= {sign, lower five scratch digits}.
  - Otherwise (|x| > 99999): saturate to BCDoutput <= {sign, 20'h99999}.
  - v <= 1 on the same edge; state -> LOAD.
- v is 0 on every other edge, so v is high for the one cycle after each output update.
- Conversion period: 20 clocks. Input is sampled once per period; changes between samples are ignored until the next LOAD.
- Latency: value present at a LOAD edge appears on BCDoutput 19 edges later (at the DONE-exit edge), with v high that cycle.
- Between updates, BCDoutput holds its value. A constant input produces an identical result every 20 cycles, with v pulsing each time.
- Sign and zero:
  - Sign bit is 1 iff input is negative; zero always gives sign 0.
  - Output digits are always valid BCD (0-9).
- First valid output after reset release: 20 cycles.

Test Plan:
- Reset held low, then released; input 0 -> BCDoutput = 21'h000000 throughout; v pulses every 20 cycles starting ~20 cycles after release.
- Positive ramp with each value held 30 cycles, checked at each v pulse:
  - 1 -> 21'h000001
  - 12 -> 21'h000012
  - 123 -> 21'h000123
  - 1234 -> 21'h001234
  - 12345 -> 21'h012345
- Overflow: 123456 -> 21'h099999 (saturated, sign 0); max positive 131071 -> 21'h099999.
- Negative values (18-bit two's complement), checked at each v pulse:
  - -1 (18'h3FFFF) -> 21'h100001
  - -12 -> 21'h100012
  - -123 -> 21'h100123
  - -1234 -> 21'h101234
  - -12345 -> 21'h112345
  - -131072 (18'h20000) -> 21'h199999
- Boundaries:
  - 99999 -> 21'h099999 (exact, no saturation)
  - 100000 -> 21'h099999 (saturated)
  - 9 -> 21'h000009
  - 10 -> 21'h000010
- Reset mid-conversion:
  - Assert rst low during SHIFT -> BCDoutput and v clear immediately.
  - After release, the next v arrives 20 cycles later with the correct result for the value sampled at the new LOAD.
  - No v pulse occurs in between.
